// File: rtl/wbm_xfer_pkg.sv
// Shared types and constants for the Wishbone word-block transfer engine.
package wbm_xfer_pkg;

    localparam int unsigned WB_ADDR_W          = 32;
    localparam int unsigned WB_DATA_W          = 32;
    localparam int unsigned WB_SEL_W           = 4;
    localparam int unsigned WB_WORD_STRIDE     = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

    localparam logic [WB_SEL_W-1:0] WB_SEL_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDAT,
        ST_BUS,
        ST_RESP,
        ST_DONE
    } xfer_state_e;

endpackage

// File: rtl/wbm_xfer_if.sv
// Command, write/read streams and Wishbone master signals of the transfer engine.
interface wbm_xfer_if
    import wbm_xfer_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [WB_ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]     cmd_len;

    logic [WB_DATA_W-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;

    logic [WB_DATA_W-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;

    logic                 busy;
    logic                 done;
    logic                 err;

    logic                 wbm_cyc_o;
    logic                 wbm_stb_o;
    logic                 wbm_we_o;
    logic [WB_SEL_W-1:0]  wbm_sel_o;
    logic [WB_ADDR_W-1:0] wbm_adr_o;
    logic [WB_DATA_W-1:0] wbm_dat_o;
    logic                 wbm_ack_i;
    logic [WB_DATA_W-1:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len,
        input  wr_data, wr_valid, rd_ready,
        input  wbm_ack_i, wbm_dat_i,
        output cmd_ready, wr_ready, rd_data, rd_valid,
        output busy, done, err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len,
        output wr_data, wr_valid, rd_ready,
        output wbm_ack_i, wbm_dat_i,
        input  cmd_ready, wr_ready, rd_data, rd_valid,
        input  busy, done, err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wbm_ack_timeout.sv
// Per-beat ack watchdog; only built when WBM_TIMEOUT_EN is defined.
`ifdef WBM_TIMEOUT_EN
module wbm_ack_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Saturates at the terminal count so expire_c holds until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expire_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/wbm_xfer_engine.sv
// Wishbone classic master moving word blocks between valid/ready streams and the bus.
// Optional ack watchdog: define WBM_TIMEOUT_EN.
module wbm_xfer_engine
    import wbm_xfer_pkg::*;
#(
    parameter int unsigned LEN_W = 16
`ifdef WBM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wbm_xfer_if.master    bus
);

    xfer_state_e          state;
    logic [WB_ADDR_W-1:0] addr_q;
    logic [WB_DATA_W-1:0] data_q;
    logic [WB_DATA_W-1:0] rd_data_q;
    logic [LEN_W-1:0]     cnt_q;
    logic [WB_SEL_W-1:0]  sel_q;
    logic                 we_q;
    logic                 cyc_q;
    logic                 we_o_q;
    logic                 cmd_ready_q;
    logic                 wr_ready_q;
    logic                 rd_valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 timeout_c;
    logic                 last_beat_c;

`ifdef WBM_TIMEOUT_EN
    wbm_ack_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ack_timeout (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clr      (state != ST_BUS),
        .en       (state == ST_BUS),
        .expire_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    assign last_beat_c = (cnt_q == LEN_W'(1));

    // Control FSM and datapath; every bus-facing output is a flop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            rd_data_q   <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            we_o_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q      <= bus.cmd_addr & ~WB_ADDR_W'(3);
                        cnt_q       <= bus.cmd_len;
                        we_q        <= bus.cmd_we;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            state <= ST_DONE;
                        end else if (bus.cmd_we) begin
                            wr_ready_q <= 1'b1;
                            state      <= ST_WDAT;
                        end else begin
                            cyc_q  <= 1'b1;
                            we_o_q <= 1'b0;
                            sel_q  <= WB_SEL_ALL;
                            state  <= ST_BUS;
                        end
                    end
                end
                ST_WDAT: begin
                    if (bus.wr_valid) begin
                        data_q     <= bus.wr_data;
                        wr_ready_q <= 1'b0;
                        cyc_q      <= 1'b1;
                        we_o_q     <= 1'b1;
                        sel_q      <= WB_SEL_ALL;
                        state      <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus.wbm_ack_i) begin
                        cyc_q  <= 1'b0;
                        we_o_q <= 1'b0;
                        sel_q  <= '0;
                        addr_q <= addr_q + WB_ADDR_W'(WB_WORD_STRIDE);
                        cnt_q  <= cnt_q - LEN_W'(1);
                        if (!we_q) begin
                            rd_data_q  <= bus.wbm_dat_i;
                            rd_valid_q <= 1'b1;
                            state      <= ST_RESP;
                        end else if (last_beat_c) begin
                            state <= ST_DONE;
                        end else begin
                            wr_ready_q <= 1'b1;
                            state      <= ST_WDAT;
                        end
                    end else if (timeout_c) begin
                        // Slave went silent: abandon the rest of the block.
                        cyc_q  <= 1'b0;
                        we_o_q <= 1'b0;
                        sel_q  <= '0;
                        err_q  <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_RESP: begin
                    if (bus.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (cnt_q == '0) begin
                            state <= ST_DONE;
                        end else begin
                            cyc_q  <= 1'b1;
                            we_o_q <= 1'b0;
                            sel_q  <= WB_SEL_ALL;
                            state  <= ST_BUS;
                        end
                    end
                end
                ST_DONE: begin
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_o_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = addr_q;
    assign bus.wbm_dat_o = data_q;

endmodule

// File: tb/tb_wbm_xfer_engine.sv
// Directed bench for wbm_xfer_engine with a delayed-ack BRAM slave model.
module tb_wbm_xfer_engine;
    import wbm_xfer_pkg::*;

    localparam int          DELAYS = 10;
    localparam logic [31:0] BASE   = 32'h3800_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wbm_xfer_if #(.LEN_W(16)) bus ();

    wbm_xfer_engine #(.LEN_W(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Slave: acks after DELAYS cycles of cyc&stb, memory indexed by adr[5:2]
    logic [31:0] mem [16];
    int          dly;
    logic        slave_mute = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            bus.wbm_ack_i <= 1'b0;
            bus.wbm_dat_i <= '0;
            dly           <= 0;
        end else if (bus.wbm_ack_i) begin
            bus.wbm_ack_i <= 1'b0;
        end else if (bus.wbm_cyc_o && bus.wbm_stb_o && !slave_mute) begin
            if (dly == DELAYS - 1) begin
                dly           <= 0;
                bus.wbm_ack_i <= 1'b1;
                bus.wbm_dat_i <= mem[bus.wbm_adr_o[5:2]];
                if (bus.wbm_we_o) mem[bus.wbm_adr_o[5:2]] = bus.wbm_dat_o;
            end else begin
                dly <= dly + 1;
            end
        end else begin
            dly <= 0;
        end
    end

    // Write-stream source
    logic [31:0] wr_words [8];
    int          wr_idx = 0;
    int          wr_n   = 0;
    assign bus.wr_valid = (wr_idx < wr_n);
    assign bus.wr_data  = wr_words[wr_idx[2:0]];
    always @(posedge clk) if (bus.wr_valid && bus.wr_ready) wr_idx <= wr_idx + 1;

    // Bus/stream monitor
    logic [31:0] b_adr [8];
    logic [31:0] b_dat [8];
    logic        b_we  [8];
    logic [3:0]  b_sel [8];
    logic [31:0] rd_log [8];
    int beat_n, cyc_rise, cyc_hi, done_n, rd_n, stab_err;
    logic        prev_cyc, prev_we;
    logic [31:0] prev_adr, prev_dat;

    initial begin
        beat_n = 0; cyc_rise = 0; cyc_hi = 0; done_n = 0; rd_n = 0; stab_err = 0;
        prev_cyc = 1'b0; prev_we = 1'b0; prev_adr = '0; prev_dat = '0;
    end

    always @(posedge clk) begin
        if (bus.wbm_cyc_o && bus.wbm_ack_i && beat_n < 8) begin
            b_adr[beat_n] = bus.wbm_adr_o;
            b_dat[beat_n] = bus.wbm_dat_o;
            b_we[beat_n]  = bus.wbm_we_o;
            b_sel[beat_n] = bus.wbm_sel_o;
            beat_n++;
        end
        if (bus.wbm_cyc_o && !prev_cyc) cyc_rise++;
        if (bus.wbm_cyc_o) cyc_hi++;
        if (bus.wbm_cyc_o && (!bus.wbm_stb_o || bus.wbm_sel_o != 4'hF)) stab_err++;
        if (bus.wbm_cyc_o && prev_cyc && (bus.wbm_adr_o != prev_adr ||
            bus.wbm_dat_o != prev_dat || bus.wbm_we_o != prev_we)) stab_err++;
        if (bus.done) done_n++;
        if (bus.rd_valid && bus.rd_ready && rd_n < 8) begin
            rd_log[rd_n] = bus.rd_data;
            rd_n++;
        end
        prev_cyc = bus.wbm_cyc_o;
        prev_adr = bus.wbm_adr_o;
        prev_dat = bus.wbm_dat_o;
        prev_we  = bus.wbm_we_o;
    end

    task automatic clear_mon();
        beat_n = 0; cyc_rise = 0; cyc_hi = 0; rd_n = 0; stab_err = 0;
    endtask

    task automatic load_words(input logic [31:0] w0, w1, w2, w3, input int n);
        logic [31:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < n; i++) wr_words[(wr_idx + i) % 8] = w[i];
        wr_n = wr_idx + n;
    endtask

    task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [15:0] len);
        int t = 0;
        @(negedge clk);
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0 = done_n;
        int t  = 0;
        while (done_n == n0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_n == n0) begin
            errors++;
            $display("FAIL done_wait: no done pulse within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.rd_valid,
             bus.wr_ready, bus.busy, bus.done, bus.err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctrl: cyc=%b stb=%b we=%b sel=%h rdv=%b wrr=%b busy=%b done=%b err=%b required all 0",
                     bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.rd_valid,
                     bus.wr_ready, bus.busy, bus.done, bus.err);
        end
        checks++;
        if ({bus.wbm_adr_o, bus.wbm_dat_o, bus.rd_data} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: adr=%h dat=%h rd_data=%h required 0",
                     bus.wbm_adr_o, bus.wbm_dat_o, bus.rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write();
        logic [31:0] exp [4];
        int n0;
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 16; i++) mem[i] = '0;
        clear_mon();
        n0 = done_n;
        load_words(32'h11, 32'h22, 32'h33, 32'h44, 4);
        issue_cmd(1'b1, BASE, 16'd4);
        wait_done(400);
        @(negedge clk);
        checks++;
        if (beat_n !== 4) begin
            errors++;
            $display("FAIL write_beats: got %0d required 4", beat_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_adr[i] !== BASE + 32'(4 * i) || b_we[i] !== 1'b1 || b_sel[i] !== 4'hF || b_dat[i] !== exp[i]) begin
                errors++;
                $display("FAIL write_beat%0d: adr=%h we=%b sel=%h dat=%h required adr=%h we=1 sel=f dat=%h",
                         i, b_adr[i], b_we[i], b_sel[i], b_dat[i], BASE + 32'(4 * i), exp[i]);
            end
            checks++;
            if (mem[i] !== exp[i]) begin
                errors++;
                $display("FAIL write_mem%0d: got %h required %h", i, mem[i], exp[i]);
            end
        end
        checks++;
        if (done_n - n0 !== 1 || cyc_rise !== 4 || stab_err !== 0) begin
            errors++;
            $display("FAIL write_proto: done_pulses=%0d cyc_rises=%0d stab_err=%0d required 1 4 0",
                     done_n - n0, cyc_rise, stab_err);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_idle: busy=%b err=%b cmd_ready=%b required 0 0 1",
                     bus.busy, bus.err, bus.cmd_ready);
        end
    endtask

    task automatic test_read();
        logic [31:0] exp [4];
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        bus.rd_ready = 1'b1;
        clear_mon();
        issue_cmd(1'b0, BASE, 16'd4);
        wait_done(400);
        @(negedge clk);
        checks++;
        if (rd_n !== 4 || beat_n !== 4 || cyc_rise !== 4 || stab_err !== 0) begin
            errors++;
            $display("FAIL read_counts: rd=%0d beats=%0d cyc_rises=%0d stab_err=%0d required 4 4 4 0",
                     rd_n, beat_n, cyc_rise, stab_err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_log[i] !== exp[i] || b_adr[i] !== BASE + 32'(4 * i) || b_we[i] !== 1'b0) begin
                errors++;
                $display("FAIL read_word%0d: data=%h adr=%h we=%b required data=%h adr=%h we=0",
                         i, rd_log[i], b_adr[i], b_we[i], exp[i], BASE + 32'(4 * i));
            end
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] held;
        int t = 0;
        bus.rd_ready = 1'b0;
        clear_mon();
        issue_cmd(1'b0, BASE + 32'h8, 16'd2);
        while (!bus.rd_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        held = bus.rd_data;
        checks++;
        if (bus.rd_valid !== 1'b1 || held !== 32'h33) begin
            errors++;
            $display("FAIL stall_first: rd_valid=%b rd_data=%h required 1 00000033", bus.rd_valid, held);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== held || bus.wbm_cyc_o !== 1'b0 || beat_n !== 1) begin
                errors++;
                $display("FAIL stall_hold: rd_valid=%b rd_data=%h cyc=%b beats=%0d required 1 %h 0 1",
                         bus.rd_valid, bus.rd_data, bus.wbm_cyc_o, beat_n, held);
            end
        end
        bus.rd_ready = 1'b1;
        wait_done(200);
        @(negedge clk);
        checks++;
        if (rd_n !== 2 || rd_log[1] !== 32'h44 || beat_n !== 2) begin
            errors++;
            $display("FAIL stall_resume: rd=%0d word1=%h beats=%0d required 2 00000044 2",
                     rd_n, rd_log[1], beat_n);
        end
    endtask

    task automatic test_len_zero();
        clear_mon();
        issue_cmd(1'b0, BASE, 16'd0);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0_accept: done=%b busy=%b cmd_ready=%b required 0 1 0",
                     bus.done, bus.busy, bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_done: done=%b busy=%b required 1 0", bus.done, bus.busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || cyc_rise !== 0) begin
            errors++;
            $display("FAIL len0_after: done=%b cyc_rises=%0d required 0 0", bus.done, cyc_rise);
        end
    endtask

    task automatic test_wrap();
        clear_mon();
        load_words(32'hA5A5_0001, 32'h5A5A_0002, 32'h0, 32'h0, 2);
        issue_cmd(1'b1, 32'hFFFF_FFFE, 16'd2);
        wait_done(200);
        @(negedge clk);
        checks++;
        if (beat_n !== 2 || b_adr[0] !== 32'hFFFF_FFFC || b_adr[1] !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_adr: beats=%0d adr0=%h adr1=%h required 2 fffffffc 00000000",
                     beat_n, b_adr[0], b_adr[1]);
        end
        checks++;
        if (mem[15] !== 32'hA5A5_0001 || mem[0] !== 32'h5A5A_0002) begin
            errors++;
            $display("FAIL wrap_mem: mem15=%h mem0=%h required a5a50001 5a5a0002", mem[15], mem[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        int t = 0;
        clear_mon();
        n0 = done_n;
        load_words(32'hA0, 32'hA1, 32'hA2, 32'hA3, 4);
        issue_cmd(1'b1, BASE, 16'd4);
        while (beat_n < 1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        while (!bus.wbm_cyc_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.wbm_cyc_o !== 1'b1 || beat_n !== 1) begin
            errors++;
            $display("FAIL rstmid_setup: cyc=%b beats=%0d required 1 1", bus.wbm_cyc_o, beat_n);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: cyc=%b stb=%b busy=%b required 0 0 0",
                     bus.wbm_cyc_o, bus.wbm_stb_o, bus.busy);
        end
        @(negedge clk);
        rst  = 1'b0;
        wr_n = wr_idx;
        repeat (5) @(negedge clk);
        checks++;
        if (done_n !== n0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_nodone: done_pulses=%0d cmd_ready=%b required 0 1", done_n - n0, bus.cmd_ready);
        end
        bus.rd_ready = 1'b1;
        clear_mon();
        issue_cmd(1'b0, BASE, 16'd2);
        wait_done(200);
        @(negedge clk);
        checks++;
        if (rd_n !== 2 || rd_log[0] !== 32'hA0 || rd_log[1] !== 32'h22) begin
            errors++;
            $display("FAIL rstmid_next: rd=%0d w0=%h w1=%h required 2 000000a0 00000022",
                     rd_n, rd_log[0], rd_log[1]);
        end
    endtask

`ifdef WBM_TIMEOUT_EN
    task automatic test_timeout();
        int n0;
        slave_mute   = 1'b1;
        bus.rd_ready = 1'b1;
        clear_mon();
        n0 = done_n;
        issue_cmd(1'b0, BASE, 16'd2);
        wait_done(300);
        @(negedge clk);
        checks++;
        if (cyc_hi !== 64 || bus.err !== 1'b1 || rd_n !== 0 || done_n - n0 !== 1 || beat_n !== 0) begin
            errors++;
            $display("FAIL timeout: cyc_cycles=%0d err=%b rd=%0d done_pulses=%0d beats=%0d required 64 1 0 1 0",
                     cyc_hi, bus.err, rd_n, done_n - n0, beat_n);
        end
        slave_mute = 1'b0;
        issue_cmd(1'b0, BASE, 16'd0);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: err=%b required 0", bus.err);
        end
        wait_done(20);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.rd_ready  = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_read_stall();
        test_len_zero();
        test_wrap();
        test_reset_mid();
`ifdef WBM_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
